mux2_arbiter: RTL and testbench



---
 rtl/mux2_arb_pkg.sv | 13 +
 rtl/mux2_gated_w.sv | 16 +
 rtl/mux2_arbiter.sv | 126 ++++++++++++
 tb/tb_mux2_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester mux arbiter.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2_gated_w.sv
// WIDTH-wide gated 2:1 multiplexer: y = (a & ~s) | (b & s) per bit.
module mux2_gated_w #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] s_vec;

    assign s_vec = {WIDTH{s}};
    assign y     = (a & ~s_vec) | (b & s_vec);

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter driving a gated 2:1 mux into one registered output stage.
// Define MUX2_ARB_LOCK_EN to hold ownership for a whole packet (until *_last).
module mux2_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready
);

    logic             slot;
    logic             prio;
    logic             rr_a;
    logic             rr_b;
    logic             grant_a;
    logic             grant_b;
    logic             accept;
    logic             acc_last;
    logic             prio_upd;
    logic [WIDTH-1:0] mux_data;

    assign slot = ~out_valid | out_ready;

    // Plain round-robin choice: a lone requester wins, a tie goes to prio.
    assign rr_a = a_valid & (~b_valid | (prio == SEL_A));
    assign rr_b = b_valid & ~rr_a;

`ifdef MUX2_ARB_LOCK_EN
    arb_state_t state;
    arb_state_t state_nxt;

    // While a packet owns the mux, the other side is shut out even if the owner idles.
    always_comb begin
        grant_a = rr_a;
        grant_b = rr_b;
        case (state)
            OWN_A: begin
                grant_a = a_valid;
                grant_b = 1'b0;
            end
            OWN_B: begin
                grant_a = 1'b0;
                grant_b = b_valid;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            if (acc_last)
                state_nxt = IDLE;
            else
                state_nxt = grant_b ? OWN_B : OWN_A;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    assign prio_upd = accept & acc_last;
`else
    assign grant_a  = rr_a;
    assign grant_b  = rr_b;
    assign prio_upd = accept;
`endif

    // rst gating keeps both readys low while reset is held.
    assign a_ready  = slot & grant_a & ~rst;
    assign b_ready  = slot & grant_b & ~rst;
    assign accept   = a_ready | b_ready;
    assign acc_last = grant_b ? b_last : a_last;

    mux2_gated_w #(
        .WIDTH (WIDTH)
    ) u_mux (
        .a (a_data),
        .b (b_data),
        .s (grant_b),
        .y (mux_data)
    );

    // Output stage: loads on accept, drains when consumed with nothing new behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            sel       <= SEL_A;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_last  <= acc_last;
            sel       <= grant_b ? SEL_B : SEL_A;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prio <= SEL_A;
        else if (prio_upd)
            prio <= grant_b ? SEL_A : SEL_B;
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Randomized and directed bench for mux2_arbiter against a behavioural model.
module tb_mux2_arbiter;

    localparam int WIDTH = 8;
`ifdef MUX2_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             a_valid, b_valid, a_last, b_last, a_ready, b_ready;
    logic [WIDTH-1:0] a_data, b_data, out_data;
    logic             sel, out_valid, out_last, out_ready;

    int checks = 0;
    int errors = 0;

    // model of the output stage and arbitration memory
    bit               m_valid, m_last, m_sel;
    logic [WIDTH-1:0] m_data;
    int               m_prio;
    int               m_owner;
    int               last_grant;

    always #5 clk = ~clk;

    mux2_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_last    (a_last),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_last    (b_last),
        .b_ready   (b_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid    = 1'b0;
        m_last     = 1'b0;
        m_sel      = 1'b0;
        m_data     = '0;
        m_prio     = 0;
        m_owner    = -1;
        last_grant = -1;
    endtask

    // Winner by the arbitration rules: -1 none, 0 A, 1 B.
    function automatic int exp_grant();
        if (LOCK && m_owner == 0) return a_valid ? 0 : -1;
        if (LOCK && m_owner == 1) return b_valid ? 1 : -1;
        if (a_valid && b_valid) return m_prio;
        if (a_valid) return 0;
        if (b_valid) return 1;
        return -1;
    endfunction

    // One clock: check at negedge, advance model on the edge, return at posedge+1.
    task automatic cycle();
        int g;
        bit slot;
        @(negedge clk);
        g    = exp_grant();
        slot = !m_valid || out_ready;
        check("a_ready", a_ready, slot && g == 0);
        check("b_ready", b_ready, slot && g == 1);
        check("out_valid", out_valid, m_valid);
        check("out_data", out_data, m_data);
        check("out_last", out_last, m_last);
        check("sel", sel, m_sel);
        @(posedge clk);
        last_grant = -1;
        if (slot && g >= 0) begin
            last_grant = g;
            m_valid    = 1'b1;
            m_data     = (g == 1) ? b_data : a_data;
            m_last     = (g == 1) ? b_last : a_last;
            m_sel      = (g == 1);
            if (!LOCK || m_last) m_prio = 1 - g;
            if (LOCK) m_owner = m_last ? -1 : g;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_sel", sel, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        a_valid   = 1'b1;
        b_valid   = 1'b1;
        a_data    = 8'h11;
        b_data    = 8'h22;
        a_last    = 1'b1;
        b_last    = 1'b1;
        out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // single A word right after reset
        b_valid = 1'b0;
        cycle();
        a_valid = 1'b0;
        check("t1_out_data", out_data, 8'h11);
        check("t1_sel", sel, 0);
        check("t1_out_valid", out_valid, 1);
        cycle();

        // both valid: per-word alternation starting at A
        do_reset();
        a_valid = 1'b1; a_data = 8'h0A; a_last = 1'b1;
        b_valid = 1'b1; b_data = 8'h0B; b_last = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("rr_data", out_data, (i % 2 == 0) ? 8'h0A : 8'h0B);
            check("rr_sel", sel, i % 2);
        end

        // stall three cycles with a word held, then release
        out_ready = 1'b0;
        cycle();
        for (int i = 0; i < 3; i++) cycle();
        out_ready = 1'b1;
        cycle();
        cycle();

`ifdef MUX2_ARB_LOCK_EN
        // A three-word packet while B waits
        do_reset();
        b_valid = 1'b1; b_data = 8'hB0; b_last = 1'b1;
        a_valid = 1'b1;
        for (int w = 1; w <= 3; w++) begin
            a_data = 8'(w);
            a_last = (w == 3);
            cycle();
            check("lock_sel_a", sel, 0);
        end
        a_valid = 1'b0;
        cycle();
        check("lock_sel_b", sel, 1);
        check("lock_data_b", out_data, 8'hB0);

        // owner idles for two cycles; B must stay locked out
        do_reset();
        a_valid = 1'b1; a_data = 8'hA1; a_last = 1'b0;
        b_valid = 1'b1;
        cycle();
        a_valid = 1'b0;
        cycle();
        cycle();
        a_valid = 1'b1; a_data = 8'hA2; a_last = 1'b1;
        cycle();
        check("lock_resume", out_data, 8'hA2);
        a_valid = 1'b0;
        cycle();
`endif

        // reset while a B word is held and stalled
        do_reset();
        a_valid = 1'b0;
        b_valid = 1'b1; b_data = 8'h5B; b_last = 1'b0;
        out_ready = 1'b0;
        cycle();
        cycle();
        check("held_sel", sel, 1);
        do_reset();
        b_data = 8'h6C; b_last = 1'b1;
        out_ready = 1'b1;
        cycle();
        check("post_rst_b", out_data, 8'h6C);

        // randomized traffic honouring the valid/ready hold rule
        for (int n = 0; n < 400; n++) begin
            if (last_grant == 0 || !a_valid) begin
                a_valid = ($urandom_range(3) != 0);
                a_data  = 8'($urandom);
                a_last  = ($urandom_range(2) == 0);
            end
            if (last_grant == 1 || !b_valid) begin
                b_valid = ($urandom_range(3) != 0);
                b_data  = 8'($urandom);
                b_last  = ($urandom_range(2) == 0);
            end
            out_ready = ($urandom_range(9) < 7);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
